// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared types and constants for the UART transmit arbiter.
//   arb_state_e  : arbiter FSM states (ID only reachable when UART_ARB_ID_PREFIX_EN is defined)
//   rel_cause_e  : why a grant was released
//   ID_MARKER    : high nibble of the per-grant header byte
//   id_header()  : builds the header byte {ID_MARKER, requester id}
package uart_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ID   = 2'd1,
      XFER = 2'd2
   } arb_state_e;

   typedef enum logic [1:0] {
      REL_LAST = 2'd0,
      REL_MAX  = 2'd1,
      REL_TMO  = 2'd2
   } rel_cause_e;

   localparam logic [3:0] ID_MARKER = 4'hA;

   function automatic logic [7:0] id_header(input logic [3:0] id);
      return {ID_MARKER, id};
   endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: combinational round-robin selector.
//   Scans req_i starting at last_i+1 and wrapping modulo NUM_REQ, returning the
//   first set position. The previous winner is therefore examined last.
// Ports:
//   req_i   in  NUM_REQ          request vector
//   last_i  in  $clog2(NUM_REQ)  most recently granted index
//   found_o out 1                at least one request set
//   idx_o   out $clog2(NUM_REQ)  selected index (0 when found_o=0)
module uart_rr_pick
   import uart_arb_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         req_i,
   input  logic [$clog2(NUM_REQ)-1:0] last_i,
   output logic                       found_o,
   output logic [$clog2(NUM_REQ)-1:0] idx_o
);

   localparam int IW = $clog2(NUM_REQ);

   logic [IW-1:0] cand_s;
   logic          hit_s;

   // Priority scan from last_i+1 around the ring; first hit wins.
   always_comb begin
      found_o = 1'b0;
      idx_o   = '0;
      cand_s  = '0;
      hit_s   = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand_s  = IW'((int'(last_i) + k) % NUM_REQ);
         hit_s   = req_i[cand_s] & ~found_o;
         idx_o   = hit_s ? cand_s : idx_o;
         found_o = found_o | hit_s;
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART THR write port among NUM_REQ byte streams.
//   Round-robin grant held for a burst; released on req_last, after MAX_BURST
//   bytes, or after TIMEOUT cycles with the grantee's valid low. Writes are
//   paced to at most one every two cycles so the registered thr_full, which
//   lags a write by one cycle, can never be overrun.
//   Optional: define UART_ARB_ID_PREFIX_EN to emit a header byte
//   {4'hA, grant id} at the start of every grant.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   req_valid    per-requester byte available
//   req_data     requester i byte at [8i+7:8i]
//   req_last     per-requester last byte of burst
//   req_ready    per-requester accept (combinational)
//   thr_full     THR FIFO full
//   thr_wr_en    THR write strobe (registered pulse)
//   thr_wdata    THR write data (registered)
//   busy         arbiter not idle
//   grant_id     current / last granted requester
//   burst_cut    pulse: grant released by MAX_BURST or TIMEOUT
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int MAX_BURST = 16,
   parameter int TIMEOUT   = 64
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ*8-1:0]       req_data,
   input  logic [NUM_REQ-1:0]         req_last,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic                       thr_full,
   output logic                       thr_wr_en,
   output logic [7:0]                 thr_wdata,
   output logic                       busy,
   output logic [$clog2(NUM_REQ)-1:0] grant_id,
   output logic                       burst_cut
);

   localparam int            GW        = $clog2(NUM_REQ);
   localparam logic [GW-1:0] LAST_RST  = GW'(NUM_REQ - 1);
   localparam logic [7:0]    BURST_LIM = 8'(MAX_BURST - 1);
   localparam logic [7:0]    IDLE_LIM  = 8'(TIMEOUT - 1);

   arb_state_e    state_q, state_d;
   logic [GW-1:0] grant_q, grant_d;
   logic [GW-1:0] last_grant_q, last_grant_d;
   logic [7:0]    burst_cnt_q, burst_cnt_d;
   logic [7:0]    idle_cnt_q, idle_cnt_d;
   logic          wr_en_q, wr_en_d;
   logic [7:0]    wdata_q, wdata_d;
   logic          cut_q, cut_d;

   logic          pick_found_s;
   logic [GW-1:0] pick_idx_s;
   logic          g_valid_s;
   logic          g_last_s;
   logic [7:0]    g_data_s;
   logic          hs_s;
   rel_cause_e    rel_cause_s;

   uart_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .req_i   (req_valid),
      .last_i  (last_grant_q),
      .found_o (pick_found_s),
      .idx_o   (pick_idx_s)
   );

   assign g_valid_s = req_valid[grant_q];
   assign g_last_s  = req_last[grant_q];
   assign g_data_s  = req_data[{grant_q, 3'b000} +: 8];

   // Next-state logic: grant selection, handshake, burst/idle counting and release.
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      burst_cnt_d  = burst_cnt_q;
      idle_cnt_d   = idle_cnt_q;
      wr_en_d      = 1'b0;
      wdata_d      = wdata_q;
      cut_d        = 1'b0;
      hs_s         = 1'b0;
      rel_cause_s  = REL_LAST;
      case (state_q)
         IDLE: begin
            if (pick_found_s) begin
               grant_d     = pick_idx_s;
               burst_cnt_d = 8'd0;
               idle_cnt_d  = 8'd0;
`ifdef UART_ARB_ID_PREFIX_EN
               state_d     = ID;
`else
               state_d     = XFER;
`endif
            end else begin
               state_d = IDLE;
            end
         end
`ifdef UART_ARB_ID_PREFIX_EN
         ID: begin
            // Header obeys the same pacing as data bytes.
            if (!thr_full && !wr_en_q) begin
               wr_en_d = 1'b1;
               wdata_d = id_header(4'(grant_q));
               state_d = XFER;
            end else begin
               state_d = ID;
            end
         end
`endif
         XFER: begin
            // A write in flight blocks the next accept: thr_full has not caught up yet.
            hs_s = g_valid_s & ~thr_full & ~wr_en_q;
            if (hs_s) begin
               wr_en_d     = 1'b1;
               wdata_d     = g_data_s;
               burst_cnt_d = burst_cnt_q + 8'd1;
               idle_cnt_d  = 8'd0;
               if (g_last_s) begin
                  rel_cause_s  = REL_LAST;
                  state_d      = IDLE;
                  last_grant_d = grant_q;
               end else if (burst_cnt_q == BURST_LIM) begin
                  rel_cause_s  = REL_MAX;
                  state_d      = IDLE;
                  last_grant_d = grant_q;
               end else begin
                  state_d = XFER;
               end
            end else if (!g_valid_s) begin
               if (idle_cnt_q == IDLE_LIM) begin
                  rel_cause_s  = REL_TMO;
                  state_d      = IDLE;
                  last_grant_d = grant_q;
               end else begin
                  idle_cnt_d = idle_cnt_q + 8'd1;
               end
            end else begin
               // Valid but held off by thr_full: not idle, counter holds.
               idle_cnt_d = idle_cnt_q;
            end
            cut_d = (state_d == IDLE) && (rel_cause_s != REL_LAST);
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Only the granted requester can see ready, and only on a real handshake.
   always_comb begin
      req_ready           = '0;
      req_ready[grant_q]  = hs_s;
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         grant_q      <= '0;
         last_grant_q <= LAST_RST;
         burst_cnt_q  <= 8'd0;
         idle_cnt_q   <= 8'd0;
         wr_en_q      <= 1'b0;
         wdata_q      <= 8'd0;
         cut_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         burst_cnt_q  <= burst_cnt_d;
         idle_cnt_q   <= idle_cnt_d;
         wr_en_q      <= wr_en_d;
         wdata_q      <= wdata_d;
         cut_q        <= cut_d;
      end
   end

   assign thr_wr_en = wr_en_q;
   assign thr_wdata = wdata_q;
   assign busy      = (state_q != IDLE);
   assign grant_id  = grant_q;
   assign burst_cut = cut_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter (NUM_REQ=4, MAX_BURST=4, TIMEOUT=8).
// A cycle-exact vector table covers single bursts and round-robin alternation;
// hand-written sequences driven by a small queue-based requester model cover
// burst cuts, THR back-pressure, timeout release, headers and reset mid-burst.
module tb_uart_tx_arbiter;

   localparam int NR = 4;
   localparam int MB = 4;
   localparam int TO = 8;
`ifdef UART_ARB_ID_PREFIX_EN
   localparam int HDR = 1;
`else
   localparam int HDR = 0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic [NR-1:0] req_valid;
   logic [NR*8-1:0] req_data;
   logic [NR-1:0] req_last;
   logic [NR-1:0] req_ready;
   logic          thr_full;
   logic          thr_wr_en;
   logic [7:0]    thr_wdata;
   logic          busy;
   logic [1:0]    grant_id;
   logic          burst_cut;

   uart_tx_arbiter #(.NUM_REQ(NR), .MAX_BURST(MB), .TIMEOUT(TO)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_last  (req_last),
      .req_ready (req_ready),
      .thr_full  (thr_full),
      .thr_wr_en (thr_wr_en),
      .thr_wdata (thr_wdata),
      .busy      (busy),
      .grant_id  (grant_id),
      .burst_cut (burst_cut)
   );

   always #5 clk = ~clk;

   int           checks;
   int           failures;
   int           cyc;
   int           cut_cnt;
   int           cut_cyc;
   int           pace_err;
   int           ovf_err;
   logic         prev_wr;
   logic         full_prev;
   logic         full_cfg;
   logic         model_on;
   logic [NR-1:0] acc;
   logic [3:0]   tab_v;
   logic [3:0]   tab_l;
   logic [31:0]  tab_d;
   logic [8:0]   rq [NR][$];
   logic [7:0]   wq[$];
   int           wcyc[$];
   logic [7:0]   expq[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   // One clock: drive inputs at negedge, observe outputs 2 time units later.
   task automatic step();
      @(negedge clk);
      cyc++;
      for (int i = 0; i < NR; i++) begin
         if (acc[i] && rq[i].size() > 0) void'(rq[i].pop_front());
      end
      full_prev = thr_full;
      thr_full  = full_cfg;
      if (model_on) begin
         for (int i = 0; i < NR; i++) begin
            req_valid[i]       = (rq[i].size() > 0);
            req_data[8*i +: 8] = (rq[i].size() > 0) ? rq[i][0][7:0] : 8'h00;
            req_last[i]        = (rq[i].size() > 0) ? rq[i][0][8] : 1'b0;
         end
      end else begin
         req_valid = tab_v;
         req_last  = tab_l;
         req_data  = tab_d;
      end
      #2;
      if (thr_wr_en) begin
         wq.push_back(thr_wdata);
         wcyc.push_back(cyc);
         if (prev_wr) pace_err++;
         if (full_prev) ovf_err++;
      end
      prev_wr = thr_wr_en;
      if (burst_cut) begin
         cut_cnt++;
         cut_cyc = cyc;
      end
      acc = req_ready & req_valid;
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      full_cfg = 1'b0;
      acc      = '0;
      for (int i = 0; i < NR; i++) rq[i].delete();
      repeat (3) step();
      rst_n = 1'b1;
   endtask

   task automatic run_until(input int n, input int budget, input string nm);
      int k;
      k = 0;
      while (wq.size() < n && k < budget) begin
         step();
         k++;
      end
      chk(nm, 32'(wq.size() >= n), 32'd1);
   endtask

   task automatic exp_hdr(input logic [3:0] id);
      if (HDR != 0) expq.push_back({4'hA, id});
   endtask

   task automatic check_stream(input string nm, input int base);
      for (int j = 0; j < expq.size(); j++) begin
         chk($sformatf("%s_b%0d", nm, j),
             (base + j < wq.size()) ? 32'(wq[base + j]) : 32'hDEAD, 32'(expq[j]));
      end
      expq.delete();
   endtask

`ifndef UART_ARB_ID_PREFIX_EN
   typedef struct {
      logic [3:0]  v;
      logic [3:0]  l;
      logic [31:0] d;
      logic [16:0] e;   // {req_ready, thr_wr_en, thr_wdata, busy, grant_id, burst_cut}
   } vec_t;
   vec_t tbl [13];
`endif

   initial begin
      int base;
      int c0;
      int w0;
      checks = 0; failures = 0; cyc = 0; cut_cnt = 0; cut_cyc = 0;
      pace_err = 0; ovf_err = 0; prev_wr = 1'b0; full_prev = 1'b0;
      rst_n = 1'b0; thr_full = 1'b0; full_cfg = 1'b0; model_on = 1'b0; acc = '0;
      req_valid = '0; req_data = '0; req_last = '0;
      tab_v = 4'b0000; tab_l = 4'b0000; tab_d = 32'h0;

`ifndef UART_ARB_ID_PREFIX_EN
      // T1: requester 0 sends 0x11, 0x22(last); then T2: requesters 0 and 2 alternate.
      tbl[0]  = '{4'b0001, 4'b0000, 32'h0000_0011, {4'b0000, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0}};
      tbl[1]  = '{4'b0001, 4'b0000, 32'h0000_0011, {4'b0001, 1'b0, 8'h00, 1'b1, 2'd0, 1'b0}};
      tbl[2]  = '{4'b0001, 4'b0001, 32'h0000_0022, {4'b0000, 1'b1, 8'h11, 1'b1, 2'd0, 1'b0}};
      tbl[3]  = '{4'b0001, 4'b0001, 32'h0000_0022, {4'b0001, 1'b0, 8'h11, 1'b1, 2'd0, 1'b0}};
      tbl[4]  = '{4'b0000, 4'b0000, 32'h0000_0000, {4'b0000, 1'b1, 8'h22, 1'b0, 2'd0, 1'b0}};
      tbl[5]  = '{4'b0000, 4'b0000, 32'h0000_0000, {4'b0000, 1'b0, 8'h22, 1'b0, 2'd0, 1'b0}};
      tbl[6]  = '{4'b0101, 4'b0101, 32'h00C2_00A0, {4'b0000, 1'b0, 8'h22, 1'b0, 2'd0, 1'b0}};
      tbl[7]  = '{4'b0101, 4'b0101, 32'h00C2_00A0, {4'b0100, 1'b0, 8'h22, 1'b1, 2'd2, 1'b0}};
      tbl[8]  = '{4'b0101, 4'b0101, 32'h00C2_00A0, {4'b0000, 1'b1, 8'hC2, 1'b0, 2'd2, 1'b0}};
      tbl[9]  = '{4'b0101, 4'b0101, 32'h00C2_00A0, {4'b0001, 1'b0, 8'hC2, 1'b1, 2'd0, 1'b0}};
      tbl[10] = '{4'b0101, 4'b0101, 32'h00C2_00A0, {4'b0000, 1'b1, 8'hA0, 1'b0, 2'd0, 1'b0}};
      tbl[11] = '{4'b0101, 4'b0101, 32'h00C2_00A0, {4'b0100, 1'b0, 8'hA0, 1'b1, 2'd2, 1'b0}};
      tbl[12] = '{4'b0000, 4'b0000, 32'h0000_0000, {4'b0000, 1'b1, 8'hC2, 1'b0, 2'd2, 1'b0}};
`endif

      do_reset();
      chk("reset_outputs", 32'({req_ready, thr_wr_en, thr_wdata, busy, grant_id, burst_cut}), 32'h0);

`ifndef UART_ARB_ID_PREFIX_EN
      for (int r = 0; r < 13; r++) begin
         tab_v = tbl[r].v;
         tab_l = tbl[r].l;
         tab_d = tbl[r].d;
         step();
         chk($sformatf("vec%0d", r),
             32'({req_ready, thr_wr_en, thr_wdata, busy, grant_id, burst_cut}), 32'(tbl[r].e));
      end
`endif

      // After reset requester 0 outranks 3; then 3, then 0 again.
      do_reset();
      model_on = 1'b1;
      base = wq.size();
      rq[0].push_back({1'b1, 8'h01}); rq[0].push_back({1'b1, 8'h02});
      rq[3].push_back({1'b1, 8'h31});
      exp_hdr(4'd0); expq.push_back(8'h01);
      exp_hdr(4'd3); expq.push_back(8'h31);
      exp_hdr(4'd0); expq.push_back(8'h02);
      run_until(base + 3 + 3*HDR, 80, "rr_reset_done");
      check_stream("rr_reset", base);

      // T3: MAX_BURST cut, waiting requester 2 served, then requester 1 resumes.
      base = wq.size();
      c0 = cut_cnt;
      for (int b = 1; b <= 6; b++) rq[1].push_back({1'b0, 8'(8'h10 + b)});
      rq[2].push_back({1'b1, 8'h21});
      exp_hdr(4'd1);
      expq.push_back(8'h11); expq.push_back(8'h12); expq.push_back(8'h13); expq.push_back(8'h14);
      exp_hdr(4'd2); expq.push_back(8'h21);
      exp_hdr(4'd1); expq.push_back(8'h15); expq.push_back(8'h16);
      run_until(base + 7 + 3*HDR, 120, "maxburst_done");
      check_stream("maxburst", base);
      for (int k = 0; k < 40 && cut_cnt < c0 + 2; k++) step();
      chk("maxburst_cuts", 32'(cut_cnt - c0), 32'd2);
      chk("maxburst_idle", 32'(busy), 32'd0);

      // T4: thr_full held 20 cycles mid-burst.
      base = wq.size();
      c0 = cut_cnt;
      rq[1].push_back({1'b0, 8'h41}); rq[1].push_back({1'b0, 8'h42}); rq[1].push_back({1'b1, 8'h43});
      exp_hdr(4'd1); expq.push_back(8'h41); expq.push_back(8'h42); expq.push_back(8'h43);
      run_until(base + 1 + HDR, 40, "full_first");
      full_cfg = 1'b1;
      w0 = wq.size();
      repeat (20) step();
      chk("full_no_writes", 32'(wq.size()), 32'(w0));
      chk("full_still_busy", 32'(busy), 32'd1);
      chk("full_no_cut", 32'(cut_cnt), 32'(c0));
      full_cfg = 1'b0;
      run_until(base + 3 + HDR, 40, "full_resume");
      check_stream("full", base);
      chk("full_no_cut_end", 32'(cut_cnt), 32'(c0));

      // T5: grantee 2 goes silent after one byte; timeout release serves 3.
      base = wq.size();
      c0 = cut_cnt;
      rq[2].push_back({1'b0, 8'h51});
      rq[3].push_back({1'b1, 8'h61});
      exp_hdr(4'd2); expq.push_back(8'h51);
      exp_hdr(4'd3); expq.push_back(8'h61);
      run_until(base + 2 + 2*HDR, 60, "timeout_done");
      chk("timeout_cuts", 32'(cut_cnt - c0), 32'd1);
      if (wcyc.size() >= base + 2 + 2*HDR) begin
         chk("timeout_delay", 32'(cut_cyc - wcyc[base + HDR]), 32'(TO));
         chk("timeout_order", 32'(wcyc[base + 1 + 2*HDR] > cut_cyc), 32'd1);
      end else begin
         chk("timeout_writes_seen", 32'(wcyc.size()), 32'(base + 2 + 2*HDR));
      end
      check_stream("timeout", base);

      // T6: single-byte burst from requester 3 (header 0xA3 when enabled).
      base = wq.size();
      rq[3].push_back({1'b1, 8'h55});
      exp_hdr(4'd3); expq.push_back(8'h55);
      run_until(base + 1 + HDR, 40, "hdr_done");
      check_stream("hdr", base);

      // Reset asserted while a write strobe is high.
      for (int b = 0; b < 8; b++) rq[0].push_back({1'b0, 8'(8'h71 + b)});
      run_until(wq.size() + 1, 40, "rst_first_wr");
      rst_n = 1'b0;
      #1;
      chk("rst_async_outputs",
          32'({req_ready, thr_wr_en, thr_wdata, busy, grant_id, burst_cut}), 32'h0);
      w0 = wq.size();
      do_reset();
      chk("rst_no_writes", 32'(wq.size()), 32'(w0));
      repeat (3) step();
      chk("rst_idle_after", 32'({busy, thr_wr_en}), 32'd0);

      chk("pacing_errors", 32'(pace_err), 32'd0);
      chk("overflow_errors", 32'(ovf_err), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
